// File: rtl/fetch_unit.sv
// Program-counter / fetch stage feeding instr_rom; captures the ROM word into an IR with valid/ready to decode.
// Optional FETCH_PERF_CNT_EN adds a saturating capture counter on fetch_count.
module fetch_unit #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 10,
    parameter int              OFF_W    = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic [PC_W-1:0]    pc_out,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [OFF_W-1:0]   branch_offset,
    input  logic               jump_en,
    input  logic [PC_W-1:0]    jump_target,
    input  logic               halt_req,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        fetch_count
`endif
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t               state_reg;
    logic [PC_W-1:0]      pc_reg;
    logic [INSTR_W-1:0]   ir_reg;
    logic [PC_W-1:0]      ipc_reg;
    logic                 valid_reg;
    logic                 halted_reg;

    logic                 in_run;
    logic                 redirect;
    logic                 advance;
    logic                 accept;
    logic                 capture;
    logic [PC_W-1:0]      offset_sext;
    logic [PC_W-1:0]      redirect_pc;

    assign in_run      = (state_reg == RUN);
    assign redirect    = in_run & (jump_en | branch_taken);
    assign advance     = in_run & ~stall & (~valid_reg | instr_ready);
    assign accept      = valid_reg & instr_ready;
    // Redirect pre-empts capture, so the counter only sees true IR loads.
    assign capture     = advance & ~redirect;
    assign offset_sext = {{(PC_W-OFF_W){branch_offset[OFF_W-1]}}, branch_offset};
    assign redirect_pc = jump_en ? jump_target : (ipc_reg + offset_sext);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= BOOT;
            pc_reg     <= RESET_PC;
            ir_reg     <= '0;
            ipc_reg    <= '0;
            valid_reg  <= 1'b0;
            halted_reg <= 1'b0;
        end else begin
            case (state_reg)
                BOOT: begin
                    state_reg <= RUN;
                end
                RUN: begin
                    if (redirect) begin
                        pc_reg    <= redirect_pc;
                        valid_reg <= 1'b0;
                    end else if (advance) begin
                        ir_reg    <= instr_in;
                        ipc_reg   <= pc_reg;
                        valid_reg <= 1'b1;
                        pc_reg    <= pc_reg + 1'b1;
                    end else if (accept) begin
                        valid_reg <= 1'b0;
                    end
                    // The redirect or capture above still lands on the halting edge.
                    if (halt_req) begin
                        state_reg  <= HALTED;
                        halted_reg <= 1'b1;
                    end
                end
                HALTED: begin
                    if (accept) begin
                        valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= BOOT;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] count_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (capture && count_reg != 16'hFFFF) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    assign fetch_count = count_reg;
`endif

    assign pc_out      = pc_reg;
    assign instr_out   = ir_reg;
    assign instr_pc    = ipc_reg;
    assign instr_valid = valid_reg;
    assign halted      = halted_reg;

endmodule
